search_ram_loader: RTL and testbench

Upstream stage of the binary search unit. Accepts a stream of DEPTH bytes over a valid/ready handshake and writes them into the 32x8 search RAM at addresses 0..DEPTH-1. Checks on the fly that the stream is non-decreasing, which binary search requires. Raises loaded/sorted_ok so the top level can gate the search start.

---
 rtl/binary_search_pkg.sv | 15 +
 rtl/search_ram_loader_order_checker.sv | 50 +++++
 rtl/search_ram_loader.sv | 111 +++++++++++
 tb/tb_search_ram_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_search_pkg.sv
// Shared widths and loader state encoding for the binary search unit.
// Imported by the loader, its order checker and the search stage.
package binary_search_pkg;

    localparam int SEARCH_ADDR_W = 5;
    localparam int SEARCH_DATA_W = 8;

    typedef enum logic [1:0] {
        L_IDLE,
        L_FILL,
        L_FLUSH,
        L_DONE
    } loader_state_t;

endpackage

// File: rtl/search_ram_loader_order_checker.sv
// Watches accepted bytes and flags the first place the stream decreases.
// Equal neighbours are legal; only a strict drop counts as a violation.
module order_checker
    import binary_search_pkg::*;
#(
    parameter int ADDR_W = SEARCH_ADDR_W,
    parameter int DATA_W = SEARCH_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              accept,
    input  logic              first_beat,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] data,
    output logic              sorted_ok,
    output logic [ADDR_W-1:0] unsorted_idx
);

    logic [DATA_W-1:0] prev;
    logic              drop;

    assign drop = accept & ~first_beat & (data < prev);

    // Previous byte register, refreshed on every accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else if (accept) begin
            prev <= data;
        end
    end

    // Sticky sorted flag with capture of the first violating index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sorted_ok    <= 1'b1;
            unsorted_idx <= '0;
        end else if (clr) begin
            sorted_ok    <= 1'b1;
            unsorted_idx <= '0;
        end else if (drop) begin
            sorted_ok <= 1'b0;
            if (sorted_ok) begin
                unsorted_idx <= idx;
            end
        end
    end

endmodule

// File: rtl/search_ram_loader.sv
// Streams DEPTH bytes into the search RAM and reports load/sort status.
// The write port lags the accepting handshake by one registered cycle.
module search_ram_loader
    import binary_search_pkg::*;
#(
    parameter int ADDR_W = SEARCH_ADDR_W,
    parameter int DATA_W = SEARCH_DATA_W,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              abort,
    input  logic              search_busy,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              loading,
    output logic              loaded,
    output logic              sorted_ok,
    output logic [ADDR_W-1:0] unsorted_idx
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    loader_state_t   state;
    loader_state_t   state_nxt;
    logic [ADDR_W:0] count;
    logic            accept;
    logic            start;
    logic            idle_or_done;

    assign idle_or_done = (state == L_IDLE) | (state == L_DONE);
    assign start        = idle_or_done & load_start & ~search_busy;
    assign in_ready     = (state == L_FILL) & ~search_busy & ~abort;
    assign accept       = in_valid & in_ready;
    assign loading      = (state == L_FILL) | (state == L_FLUSH);

    // Next-state selection; abort only matters while filling.
    always_comb begin
        state_nxt = state;
        unique case (state)
            L_IDLE:  if (start) state_nxt = L_FILL;
            L_FILL: begin
                if (abort) begin
                    state_nxt = L_IDLE;
                end else if (accept && count == LAST) begin
                    state_nxt = L_FLUSH;
                end
            end
            L_FLUSH: state_nxt = L_DONE;
            L_DONE:  if (start) state_nxt = L_FILL;
            default: state_nxt = L_IDLE;
        endcase
    end

    // State, beat counter and the loaded flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= L_IDLE;
            count  <= '0;
            loaded <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                count  <= '0;
                loaded <= 1'b0;
            end else if (accept) begin
                count <= count + ONE;
            end
            if (state == L_FLUSH) begin
                loaded <= 1'b1;
            end
        end
    end

    // Registered RAM write port driven by accepted beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= count[ADDR_W-1:0];
                wr_data <= in_data;
            end
        end
    end

    order_checker #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_order (
        .clk         (clk),
        .reset       (reset),
        .clr         (start),
        .accept      (accept),
        .first_beat  (count == '0),
        .idx         (count[ADDR_W-1:0]),
        .data        (in_data),
        .sorted_ok   (sorted_ok),
        .unsorted_idx(unsorted_idx)
    );

endmodule

// File: tb/tb_search_ram_loader.sv
// Directed bench for search_ram_loader.
// Inputs change on the falling edge, outputs are read away from the rising edge.
module tb_search_ram_loader;

    logic       clk;
    logic       reset;
    logic       load_start;
    logic       abort;
    logic       search_busy;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       loading;
    logic       loaded;
    logic       sorted_ok;
    logic [4:0] unsorted_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] vec[32];
    int waddr[$];
    int wdata[$];
    int wcyc[$];

    search_ram_loader dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .abort       (abort),
        .search_busy (search_busy),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .loading     (loading),
        .loaded      (loaded),
        .sorted_ok   (sorted_ok),
        .unsorted_idx(unsorted_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: logs every RAM write a little after the edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (wr_en === 1'b1) begin
            waddr.push_back(int'(wr_addr));
            wdata.push_back(int'(wr_data));
            wcyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        waddr.delete();
        wdata.delete();
        wcyc.delete();
    endtask

    task automatic set_sorted_vec();
        for (int i = 0; i < 32; i++) vec[i] = 8'(3 * i);
        vec[2] = 8'd3;
        vec[3] = 8'd7;
    endtask

    task automatic do_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Producer: pushes vec[] with optional gaps, busy window and abort.
    task automatic feed(input bit gaps, input int busy_at,
                        input int abort_at, output int got);
        int i;
        int t;
        bit acc;
        i = 0;
        t = 0;
        while (i < 32 && t < 300) begin
            search_busy = (t >= busy_at) && (t < busy_at + 3);
            in_valid    = gaps ? ((t % 2) == 0) : 1'b1;
            in_data     = vec[i];
            if (i == abort_at) begin
                abort    = 1'b1;
                in_valid = 1'b1;
            end
            #1;
            if (search_busy || abort) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ready_blocked t=%0d: in_ready=%b want 0",
                             t, in_ready);
                end
            end
            acc = in_valid & in_ready;
            @(negedge clk);
            if (abort) begin
                abort    = 1'b0;
                in_valid = 1'b0;
                break;
            end
            if (acc) i++;
            t++;
        end
        in_valid    = 1'b0;
        search_busy = 1'b0;
        got = i;
        n_cmp++;
        if (t >= 300) begin
            n_bad++;
            $display("FAIL feed_timeout: beats=%0d want 32", i);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, wr_en, loading, loaded, sorted_ok} !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00001",
                     {in_ready, wr_en, loading, loaded, sorted_ok});
        end
        n_cmp++;
        if ({wr_addr, wr_data, unsorted_idx} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_buses: addr=%0d data=%0d idx=%0d want 0",
                     wr_addr, wr_data, unsorted_idx);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int got;
        set_sorted_vec();
        clear_log();
        do_start();
        n_cmp++;
        if (in_ready !== 1'b1 || loaded !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_fill: ready=%b loaded=%b want 1 0",
                     in_ready, loaded);
        end
        feed(1'b0, 1000, -1, got);
        n_cmp++;
        if (wr_en !== 1'b1 || loaded !== 1'b0 || loading !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_last_wr: wr_en=%b loaded=%b loading=%b want 1 0 1",
                     wr_en, loaded, loading);
        end
        @(negedge clk);
        n_cmp++;
        if (loaded !== 1'b1 || wr_en !== 1'b0 || loading !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_loaded: loaded=%b wr_en=%b loading=%b want 1 0 0",
                     loaded, wr_en, loading);
        end
        n_cmp++;
        if (sorted_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_sorted: sorted_ok=%b want 1", sorted_ok);
        end
        n_cmp++;
        if (waddr.size() != 32) begin
            n_bad++;
            $display("FAIL b2b_count: writes=%0d want 32", waddr.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                n_cmp++;
                if (waddr[k] != k || wdata[k] != int'(vec[k]) ||
                    wcyc[k] - wcyc[0] != k) begin
                    n_bad++;
                    $display("FAIL b2b_write%0d: addr=%0d data=%0d dcyc=%0d want %0d %0d %0d",
                             k, waddr[k], wdata[k], wcyc[k] - wcyc[0],
                             k, vec[k], k);
                end
            end
        end
    endtask

    task automatic test_unsorted();
        int got;
        for (int i = 0; i < 32; i++) vec[i] = 8'(2 * i);
        vec[9]  = 8'd50;
        vec[10] = 8'd40;
        vec[20] = 8'd30;
        clear_log();
        do_start();
        n_cmp++;
        if (sorted_ok !== 1'b1 || unsorted_idx !== 5'd0 || loaded !== 1'b0) begin
            n_bad++;
            $display("FAIL uns_clear: ok=%b idx=%0d loaded=%b want 1 0 0",
                     sorted_ok, unsorted_idx, loaded);
        end
        feed(1'b0, 1000, -1, got);
        @(negedge clk);
        n_cmp++;
        if (sorted_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL uns_flag: sorted_ok=%b want 0", sorted_ok);
        end
        n_cmp++;
        if (unsorted_idx !== 5'd10) begin
            n_bad++;
            $display("FAIL uns_idx: unsorted_idx=%0d want 10", unsorted_idx);
        end
        n_cmp++;
        if (loaded !== 1'b1) begin
            n_bad++;
            $display("FAIL uns_loaded: loaded=%b want 1", loaded);
        end
    endtask

    task automatic test_backpressure();
        int got;
        set_sorted_vec();
        clear_log();
        do_start();
        feed(1'b1, 20, -1, got);
        @(negedge clk);
        n_cmp++;
        if (waddr.size() != 32) begin
            n_bad++;
            $display("FAIL bp_count: writes=%0d want 32", waddr.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                n_cmp++;
                if (waddr[k] != k || wdata[k] != int'(vec[k])) begin
                    n_bad++;
                    $display("FAIL bp_write%0d: addr=%0d data=%0d want %0d %0d",
                             k, waddr[k], wdata[k], k, vec[k]);
                end
            end
        end
        n_cmp++;
        if (loaded !== 1'b1 || sorted_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_done: loaded=%b ok=%b want 1 1", loaded, sorted_ok);
        end
    endtask

    task automatic test_abort();
        int got;
        set_sorted_vec();
        clear_log();
        do_start();
        feed(1'b0, 1000, 17, got);
        n_cmp++;
        if (wr_en !== 1'b0 || loading !== 1'b0 || loaded !== 1'b0 ||
            in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: wr_en=%b loading=%b loaded=%b ready=%b want 0 0 0 0",
                     wr_en, loading, loaded, in_ready);
        end
        n_cmp++;
        if (waddr.size() != 17) begin
            n_bad++;
            $display("FAIL abort_writes: writes=%0d want 17", waddr.size());
        end
        clear_log();
        do_start();
        feed(1'b0, 1000, -1, got);
        @(negedge clk);
        n_cmp++;
        if (waddr.size() == 0 || waddr[0] != 0 || waddr.size() != 32) begin
            n_bad++;
            $display("FAIL abort_restart: writes=%0d first=%0d want 32 0",
                     waddr.size(), waddr.size() ? waddr[0] : -1);
        end
    endtask

    task automatic test_reset_flush();
        int got;
        set_sorted_vec();
        do_start();
        feed(1'b0, 1000, -1, got);
        n_cmp++;
        if (wr_en !== 1'b1 || loading !== 1'b1) begin
            n_bad++;
            $display("FAIL rf_in_flush: wr_en=%b loading=%b want 1 1",
                     wr_en, loading);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (wr_en !== 1'b0 || loading !== 1'b0 || loaded !== 1'b0) begin
            n_bad++;
            $display("FAIL rf_async: wr_en=%b loading=%b loaded=%b want 0 0 0",
                     wr_en, loading, loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (loading !== 1'b0 || loaded !== 1'b0 || in_ready !== 1'b0 ||
            sorted_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL rf_idle: loading=%b loaded=%b ready=%b ok=%b want 0 0 0 1",
                     loading, loaded, in_ready, sorted_ok);
        end
    endtask

    task automatic test_blocked_start();
        int got;
        set_sorted_vec();
        do_start();
        feed(1'b0, 1000, -1, got);
        @(negedge clk);
        search_busy = 1'b1;
        load_start  = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        n_cmp++;
        if (loaded !== 1'b1 || loading !== 1'b0) begin
            n_bad++;
            $display("FAIL blk_hold: loaded=%b loading=%b want 1 0",
                     loaded, loading);
        end
        search_busy = 1'b0;
        abort       = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (loaded !== 1'b1 || loading !== 1'b0) begin
            n_bad++;
            $display("FAIL blk_abort_done: loaded=%b loading=%b want 1 0",
                     loaded, loading);
        end
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        n_cmp++;
        if (loaded !== 1'b0 || loading !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL blk_start: loaded=%b loading=%b ready=%b want 0 1 1",
                     loaded, loading, in_ready);
        end
    endtask

    initial begin
        reset       = 1'b1;
        load_start  = 1'b0;
        abort       = 1'b0;
        search_busy = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_back_to_back();
        test_unsorted();
        test_backpressure();
        test_abort();
        test_reset_flush();
        test_blocked_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
